led_code_ctrl: RTL and testbench

Status-LED controller that shares the board's single LED between a free-running heartbeat and up to N_REQ requesters that flash numeric blink codes. While no request is pending, the LED shows the heartbeat square wave. A pending request is granted by fixed priority, its code is shown as a framed burst of blinks, and it is then acknowledged. The block sits at the top level between the status/error sources and the LED pin.

---
 rtl/led_code_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_led_code_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_code_ctrl.sv
// Status-LED controller: a free-running heartbeat shares one LED with
// fixed-priority requesters whose numeric codes are flashed as framed blink bursts.
module led_code_ctrl #(
  parameter int N_REQ     = 4,
  parameter int CODE_W    = 4,
  parameter int TICK_DIV  = 12_500_000,
  parameter int ON_TICKS  = 2,
  parameter int OFF_TICKS = 2,
  parameter int GAP_TICKS = 6,
  parameter int HB_W      = 24,
  localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ*CODE_W-1:0] i_code,
  output logic [N_REQ-1:0]        o_ack,
  output logic                    o_busy,
  output logic [ID_W-1:0]         o_grant_id,
  output logic                    o_led
);

  localparam int PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAX_T_A = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int MAX_T   = (GAP_TICKS > MAX_T_A) ? GAP_TICKS : MAX_T_A;
  localparam int TM_W    = $clog2(MAX_T + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEAD = 3'd1,
    ON   = 3'd2,
    OFF  = 3'd3,
    TAIL = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t              state_r;
  logic [HB_W-1:0]     hb_r;
  logic [PS_W-1:0]     presc_r;
  logic [TM_W-1:0]     tmr_r;
  logic [CODE_W-1:0]   cnt_r;
  logic [ID_W-1:0]     grant_r;
  logic                led_r;
  logic                busy_r;
  logic [N_REQ-1:0]    ack_r;

  logic                any_req_s;
  logic [ID_W-1:0]     req_id_s;
  logic [CODE_W-1:0]   req_code_s;
  logic                tick_s;
  logic [TM_W-1:0]     lim_s;
  logic                phase_end_s;
  logic [CODE_W-1:0]   cnt_dec_s;

  function automatic logic [N_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
    id_onehot = N_REQ'(1'b1) << id;
  endfunction

  // Fixed-priority pick: the lowest set request index wins.
  always_comb begin
    any_req_s = |i_req;
    req_id_s  = {ID_W{1'b0}};
    for (int k = N_REQ - 1; k >= 0; k--) begin
      req_id_s = i_req[k] ? ID_W'(k) : req_id_s;
    end
    req_code_s = i_code[int'(req_id_s)*CODE_W +: CODE_W];
  end

  // Per-state tick limit and end-of-phase detection.
  always_comb begin
    tick_s = (presc_r == PS_W'(TICK_DIV - 1));
    case (state_r)
      LEAD, TAIL: lim_s = TM_W'(GAP_TICKS - 1);
      ON:         lim_s = TM_W'(ON_TICKS - 1);
      OFF:        lim_s = TM_W'(OFF_TICKS - 1);
      default:    lim_s = {TM_W{1'b0}};
    endcase
    phase_end_s = tick_s && (tmr_r == lim_s);
    cnt_dec_s   = cnt_r - CODE_W'(1);
  end

  // Free-running heartbeat; grants never disturb it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hb_r <= {HB_W{1'b0}};
    end else begin
      hb_r <= hb_r + HB_W'(1);
    end
  end

  // Display sequencer; LED, busy, ack and grant move on the same edge as the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= IDLE;
      presc_r <= {PS_W{1'b0}};
      tmr_r   <= {TM_W{1'b0}};
      cnt_r   <= {CODE_W{1'b0}};
      grant_r <= {ID_W{1'b0}};
      led_r   <= 1'b0;
      busy_r  <= 1'b0;
      ack_r   <= {N_REQ{1'b0}};
    end else begin
      // Prescaler and phase timer restart on every state entry.
      if (phase_end_s || (state_r == IDLE) || (state_r == DONE)) begin
        presc_r <= {PS_W{1'b0}};
        tmr_r   <= {TM_W{1'b0}};
      end else if (tick_s) begin
        presc_r <= {PS_W{1'b0}};
        tmr_r   <= tmr_r + TM_W'(1);
      end else begin
        presc_r <= presc_r + PS_W'(1);
      end

      case (state_r)
        IDLE: begin
          ack_r <= {N_REQ{1'b0}};
          if (any_req_s) begin
            grant_r <= req_id_s;
            cnt_r   <= req_code_s;
            busy_r  <= 1'b1;
            led_r   <= 1'b0;
            if (req_code_s == {CODE_W{1'b0}}) begin
              state_r <= DONE;
              ack_r   <= id_onehot(req_id_s);
            end else begin
              state_r <= LEAD;
            end
          end else begin
            busy_r <= 1'b0;
            led_r  <= hb_r[HB_W-1];
          end
        end
        LEAD: begin
          if (phase_end_s) begin
            state_r <= ON;
            led_r   <= 1'b1;
          end
        end
        ON: begin
          if (phase_end_s) begin
            state_r <= OFF;
            led_r   <= 1'b0;
          end
        end
        OFF: begin
          if (phase_end_s) begin
            cnt_r <= cnt_dec_s;
            if (cnt_dec_s != {CODE_W{1'b0}}) begin
              state_r <= ON;
              led_r   <= 1'b1;
            end else begin
              state_r <= TAIL;
            end
          end
        end
        TAIL: begin
          if (phase_end_s) begin
            state_r <= DONE;
            ack_r   <= id_onehot(grant_r);
          end
        end
        DONE: begin
          state_r <= IDLE;
          ack_r   <= {N_REQ{1'b0}};
          busy_r  <= 1'b0;
          led_r   <= hb_r[HB_W-1];
        end
        default: begin
          state_r <= IDLE;
          ack_r   <= {N_REQ{1'b0}};
          busy_r  <= 1'b0;
          led_r   <= 1'b0;
        end
      endcase
    end
  end

  assign o_ack      = ack_r;
  assign o_busy     = busy_r;
  assign o_grant_id = grant_r;
  assign o_led      = led_r;

endmodule

// File: tb/tb_led_code_ctrl.sv
// Scoreboard bench for led_code_ctrl: stimulus queues expected displays,
// a monitor checks every display and every idle cycle against a behavioural model.
module tb_led_code_ctrl;

  localparam int N_REQ     = 4;
  localparam int CODE_W    = 4;
  localparam int TICK_DIV  = 4;
  localparam int ON_TICKS  = 2;
  localparam int OFF_TICKS = 2;
  localparam int GAP_TICKS = 3;
  localparam int HB_W      = 4;

  localparam int GAP = GAP_TICKS * TICK_DIV;
  localparam int PER = (ON_TICKS + OFF_TICKS) * TICK_DIV;
  localparam int ONC = ON_TICKS * TICK_DIV;

  logic                    clk = 1'b0;
  logic                    i_rst = 1'b1;
  logic [N_REQ-1:0]        i_req = '0;
  logic [N_REQ*CODE_W-1:0] i_code = '0;
  logic [N_REQ-1:0]        o_ack;
  logic                    o_busy;
  logic [1:0]              o_grant_id;
  logic                    o_led;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int id;
    int code;
    bit aborted;
    bit after_rst;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  led_code_ctrl #(
    .N_REQ(N_REQ), .CODE_W(CODE_W), .TICK_DIV(TICK_DIV), .ON_TICKS(ON_TICKS),
    .OFF_TICKS(OFF_TICKS), .GAP_TICKS(GAP_TICKS), .HB_W(HB_W)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_code(i_code),
    .o_ack(o_ack), .o_busy(o_busy), .o_grant_id(o_grant_id), .o_led(o_led)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: busy length and LED level at offset j of a display of code c.
  function automatic int exp_len(input int c);
    return (c == 0) ? 1 : (2 * GAP + c * PER + 1);
  endfunction

  function automatic bit exp_led(input int c, input int j);
    if (c == 0 || j < GAP || j >= GAP + c * PER) return 1'b0;
    return ((j - GAP) % PER) < ONC;
  endfunction

  function automatic void push(input int id, input int code, input bit ab, input bit ar);
    exp_t e;
    e.id = id; e.code = code; e.aborted = ab; e.after_rst = ar;
    exp_q.push_back(e);
  endfunction

  // Heartbeat model: counts cycles since reset, wraps at 2^HB_W.
  int hb_m = 0;
  int hb_snap = 0;
  bit rst_edge = 1'b0;
  always @(posedge clk) begin
    hb_snap  <= hb_m;
    rst_edge <= i_rst;
    hb_m     <= i_rst ? 0 : (hb_m + 1) % (1 << HB_W);
  end

  initial begin : monitor
    exp_t cur;
    bit active;
    bit prev_led;
    int off, blinks, wave_err, last_id, rst_age;
    logic [N_REQ-1:0] exp_ack;
    active = 1'b0; prev_led = 1'b0;
    off = 0; blinks = 0; wave_err = 0; last_id = 0; rst_age = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (rst_edge) begin
        if (active) begin
          check("abort_expected", 32'd1, 32'(cur.aborted));
          active = 1'b0;
        end
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_led", 32'(o_led), 32'd0);
        check("rst_ack", 32'(o_ack), 32'd0);
        check("rst_grant", 32'(o_grant_id), 32'd0);
        last_id = 0;
        rst_age = 0;
      end else begin
        rst_age++;
        if (active && !o_busy) begin
          check("busy_len", 32'(off), 32'(exp_len(cur.code)));
          check("blink_count", 32'(blinks), 32'(cur.code));
          check("wave_errors", 32'(wave_err), 32'd0);
          check("not_aborted", 32'd0, 32'(cur.aborted));
          active = 1'b0;
        end
        if (!active) begin
          if (o_busy === 1'b1) begin
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_grant: got id %0d, expected no grant", o_grant_id);
              cur.id = -1; cur.code = 0; cur.aborted = 1'b0; cur.after_rst = 1'b0;
            end else begin
              cur = exp_q.pop_front();
              check("grant_id", 32'(o_grant_id), 32'(cur.id));
              if (cur.after_rst) check("regrant_latency", 32'(rst_age), 32'd1);
            end
            active = 1'b1; off = 0; blinks = 0; wave_err = 0; prev_led = 1'b0;
            last_id = cur.id;
          end else begin
            check("heartbeat_led", 32'(o_led), 32'(hb_snap[HB_W-1]));
            check("idle_ack", 32'(o_ack), 32'd0);
            check("grant_hold", 32'(o_grant_id), 32'(last_id));
          end
        end
        if (active) begin
          exp_ack = (off == exp_len(cur.code) - 1) ? N_REQ'(1 << cur.id) : '0;
          if (o_led !== exp_led(cur.code, off)) wave_err++;
          if (o_ack !== exp_ack) wave_err++;
          if (o_grant_id !== 2'(cur.id)) wave_err++;
          if (o_led === 1'b1 && !prev_led) blinks++;
          prev_led = (o_led === 1'b1);
          off++;
        end
      end
    end
  end

  task automatic set_code(input int k, input int c);
    i_code[k*CODE_W +: CODE_W] = CODE_W'(c);
  endtask

  // Returns just after the edge that ends the DONE cycle carrying o_ack[k].
  task automatic wait_ack(input int k);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (o_ack[k] !== 1'b1 && t < 2000);
    check("ack_seen", 32'(o_ack[k] === 1'b1), 32'd1);
    @(posedge clk);
    #2;
  endtask

  // Returns on the negedge of the first busy cycle.
  task automatic wait_busy();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (o_busy !== 1'b1 && t < 200);
    check("busy_seen", 32'(o_busy === 1'b1), 32'd1);
  endtask

  initial begin : stim
    int k, c, c0;
    logic [N_REQ-1:0] mask;
    repeat (3) @(posedge clk);
    #2 i_rst = 1'b0;

    // Idle heartbeat
    repeat (40) @(posedge clk);
    #2;

    // Single code 3 on requester 2
    set_code(2, 3);
    push(2, 3, 1'b0, 1'b0);
    i_req = 4'b0100;
    wait_ack(2);
    i_req = 4'b0000;

    // Priority and hold: id 1 twice, then id 3
    set_code(1, 1);
    set_code(3, 2);
    push(1, 1, 1'b0, 1'b0);
    push(1, 1, 1'b0, 1'b0);
    push(3, 2, 1'b0, 1'b0);
    i_req = 4'b1010;
    wait_ack(1);
    wait_ack(1);
    i_req[1] = 1'b0;
    wait_ack(3);
    i_req = 4'b0000;

    // Code 0 and maximum code
    k = $urandom_range(0, 3);
    set_code(k, 0);
    push(k, 0, 1'b0, 1'b0);
    i_req = N_REQ'(1 << k);
    wait_ack(k);
    i_req = 4'b0000;
    k = $urandom_range(0, 3);
    set_code(k, 15);
    push(k, 15, 1'b0, 1'b0);
    i_req = N_REQ'(1 << k);
    wait_ack(k);
    i_req = 4'b0000;

    // Random multi-requester rounds; each requester drops after its own ack
    for (int r = 0; r < 6; r++) begin
      mask = N_REQ'($urandom_range(1, 15));
      for (int j = 0; j < N_REQ; j++) begin
        if (mask[j]) begin
          c = $urandom_range(0, 5);
          set_code(j, c);
          push(j, c, 1'b0, 1'b0);
        end
      end
      i_req = mask;
      for (int j = 0; j < N_REQ; j++) begin
        if (mask[j]) begin
          wait_ack(j);
          i_req[j] = 1'b0;
        end
      end
    end

    // Input change during the second blink
    c0 = $urandom_range(2, 15);
    set_code(0, c0);
    push(0, c0, 1'b0, 1'b0);
    i_req = 4'b0001;
    wait_busy();
    repeat (29) @(negedge clk);
    @(posedge clk);
    #2;
    set_code(0, (c0 + 7) % 16);
    i_req = 4'b0000;
    wait_ack(0);

    // Reset during an ON phase with the request held
    k = $urandom_range(0, 3);
    c = $urandom_range(1, 15);
    set_code(k, c);
    push(k, c, 1'b1, 1'b0);
    push(k, c, 1'b0, 1'b1);
    i_req = N_REQ'(1 << k);
    wait_busy();
    repeat (13) @(negedge clk);
    @(posedge clk);
    #2 i_rst = 1'b1;
    @(posedge clk);
    #2 i_rst = 1'b0;
    wait_ack(k);
    i_req = 4'b0000;

    repeat (20) @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
